// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
// Run controller between the bench and the RV32I pipeline core. After the
// external reset releases, it holds the core in reset for RST_CYCLES edges.
// It then lets the core run while counting cycles and retired instructions.
// The run ends on a tohost store, which reports pass or fail with an exit
// code, or on a cycle timeout. When the run ends, the core is frozen in reset.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset, overrides everything
//   retire_valid one instruction retired this cycle (WB stage)
//   mem_we       data-memory write strobe from the core
//   mem_addr     data-memory write address
//   mem_wdata    data-memory write data
//   core_rst     reset to the core, active-high (high outside RUN)
//   running      high while the core is running
//   done         run finished, sticky until rst
//   pass / fail  tohost reported success / failure
//   timeout      cycle budget exhausted without a tohost report
//   exit_code    mem_wdata[31:1] of a failing tohost write
//   cycle_cnt    edges spent in RUN (saturating)
//   instret_cnt  retire_valid pulses seen in RUN (saturating)
module sim_run_ctrl #(
    parameter int          RST_CYCLES  = 2,
    parameter int          MAX_CYCLES  = 500,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      exit_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // hold_cnt only has to reach RST_CYCLES-1, so it needs at least one bit
    localparam int               HOLD_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
    localparam bit                TIMEOUT_EN = (MAX_CYCLES != 0);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tohost_hit;
    logic              timeout_hit;

    // A tohost store only counts when bit 0 is set; the rest of the word is the report
    assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    // Evaluated before the increment, so the run ends with cycle_cnt == MAX_CYCLES
    assign timeout_hit = TIMEOUT_EN && (cycle_cnt == TIMEOUT_AT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (tohost_hit || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        core_rst = (state != RUN);
        running  = (state == RUN);
        done     = (state == DONE);
    end

    // Reset sequencing counter, only meaningful while in HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if ((state == HOLD) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
        end
    end

    // Saturating run counters; the terminating edge is still counted
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (state == RUN) begin
            if (cycle_cnt != CNT_MAX) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (retire_valid && (instret_cnt != CNT_MAX)) begin
                instret_cnt <= instret_cnt + CNT_ONE;
            end
        end
    end

    // Completion status; a tohost report takes priority over a coincident timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
        end else if (state == RUN) begin
            if (tohost_hit) begin
                if (mem_wdata == 32'h0000_0001) begin
                    pass <= 1'b1;
                end else begin
                    fail      <= 1'b1;
                    exit_code <= mem_wdata[31:1];
                end
            end else if (timeout_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl
// Self-checking bench for sim_run_ctrl. The driver issues randomized runs and
// pushes the expected run result into a queue as the terminating stimulus is
// issued. A separate monitor pops and compares the result whenever done rises.
// A second instance with narrow counters and no timeout covers saturation.
module tb_sim_run_ctrl;

    localparam int          RST_CYCLES = 2;
    localparam int          MAX_CYCLES = 500;
    localparam int          CNT_W      = 32;
    localparam logic [31:0] TOHOST     = 32'h0000_1000;

    typedef struct {
        bit          isPass;
        bit          isFail;
        bit          isTimeout;
        logic [30:0] code;
        logic [31:0] cycles;
        logic [31:0] instret;
    } result_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             retire_valid;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             core_rst;
    logic             running;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [30:0]      exit_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    logic             rst2;
    logic             retire2;
    logic             we2;
    logic [31:0]      addr2;
    logic [31:0]      wdata2;
    logic             core_rst2;
    logic             running2;
    logic             done2;
    logic             pass2;
    logic             fail2;
    logic             timeout2;
    logic [30:0]      exit_code2;
    logic [3:0]       cycle2;
    logic [3:0]       instret2;

    int      testsRun    = 0;
    int      testsFailed = 0;
    result_t expQ[$];
    result_t lastExp;
    logic    doneSeen = 1'b0;

    always #5 clk = ~clk;

    sim_run_ctrl #(
        .RST_CYCLES (RST_CYCLES),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W),
        .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .retire_valid(retire_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_rst    (core_rst),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    sim_run_ctrl #(
        .RST_CYCLES (3),
        .MAX_CYCLES (0),
        .CNT_W      (4),
        .TOHOST_ADDR(TOHOST)
    ) satDut (
        .clk         (clk),
        .rst         (rst2),
        .retire_valid(retire2),
        .mem_we      (we2),
        .mem_addr    (addr2),
        .mem_wdata   (wdata2),
        .core_rst    (core_rst2),
        .running     (running2),
        .done        (done2),
        .pass        (pass2),
        .fail        (fail2),
        .timeout     (timeout2),
        .exit_code   (exit_code2),
        .cycle_cnt   (cycle2),
        .instret_cnt (instret2)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Drive one set of inputs at the falling edge and return at the next falling edge
    task automatic applyStimulus(input logic r, input logic rv, input logic we,
                                 input logic [31:0] a, input logic [31:0] d);
        rst          = r;
        retire_valid = rv;
        mem_we       = we;
        mem_addr     = a;
        mem_wdata    = d;
        @(negedge clk);
    endtask

    task automatic checkResetState();
        checkOutput("rst_core_rst", core_rst, 1);
        checkOutput("rst_running", running, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_fail", fail, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_exit_code", exit_code, 0);
        checkOutput("rst_cycle_cnt", cycle_cnt, 0);
        checkOutput("rst_instret_cnt", instret_cnt, 0);
    endtask

    // Release reset and expect core_rst to drop after exactly RST_CYCLES edges,
    // while tohost writes and retires in HOLD are ignored
    task automatic checkHold();
        for (int i = 0; i < RST_CYCLES; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, 32'h1);
            if (i < RST_CYCLES - 1) begin
                checkOutput("hold_core_rst", core_rst, 1);
            end else begin
                checkOutput("hold_end_core_rst", core_rst, 0);
                checkOutput("hold_end_running", running, 1);
                checkOutput("hold_end_cycle_cnt", cycle_cnt, 0);
                checkOutput("hold_end_instret_cnt", instret_cnt, 0);
                checkOutput("hold_end_done", done, 0);
            end
        end
    endtask

    task automatic doReset(input int edges);
        for (int i = 0; i < edges; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        checkResetState();
        checkHold();
    endtask

    // One run in RUN. termAt: RUN-cycle index of the tohost write (-1 for none).
    // noiseMode 1 adds random ignored writes; 2 issues two specific ignored writes.
    // abortAt: RUN-cycle index at which rst is asserted instead (-1 for none).
    task automatic doRun(input int termAt, input logic [31:0] termData, input bit useMask,
                         input logic [15:0] mask, input int noiseMode, input int abortAt);
        int          k;
        int          retired;
        int          w;
        bit          finished;
        bit          hit;
        logic        rv;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        result_t     e;
        k        = 0;
        retired  = 0;
        finished = 1'b0;
        while (!finished) begin
            if (useMask) begin
                rv = (k < 16) ? mask[k[3:0]] : 1'b0;
            end else begin
                rv = 1'($urandom_range(1));
            end
            we = 1'b0;
            a  = ($urandom_range(1) == 1) ? TOHOST : $urandom;
            d  = $urandom;
            if (k == abortAt) begin
                applyStimulus(1'b1, rv, 1'b1, TOHOST, 32'h1);
                checkResetState();
                checkHold();
                return;
            end
            hit = (k == termAt);
            if (hit) begin
                we = 1'b1;
                a  = TOHOST;
                d  = termData;
            end else if (noiseMode == 2 && k == 0) begin
                we = 1'b1;
                a  = TOHOST;
                d  = 32'h6;
            end else if (noiseMode == 2 && k == 1) begin
                we = 1'b1;
                a  = 32'h1004;
                d  = 32'h7;
            end else if (noiseMode == 1 && $urandom_range(3) == 0) begin
                we = 1'b1;
                if ($urandom_range(1) == 1) begin
                    a = TOHOST;
                    d = $urandom & ~32'h1;
                end else begin
                    a = TOHOST ^ (($urandom_range(1023) + 1) << 2);
                    d = $urandom | 32'h1;
                end
            end
            if (rv) begin
                retired++;
            end
            if (hit || (MAX_CYCLES != 0 && k == MAX_CYCLES - 1)) begin
                e.isPass    = hit && (termData == 32'h1);
                e.isFail    = hit && (termData != 32'h1);
                e.isTimeout = !hit;
                e.code      = e.isFail ? termData[31:1] : 31'h0;
                e.cycles    = k + 1;
                e.instret   = retired;
                expQ.push_back(e);
                lastExp  = e;
                finished = 1'b1;
            end
            applyStimulus(1'b0, rv, we, a, d);
            k++;
        end
        w = 0;
        #1;
        while (expQ.size() != 0 && w < 4) begin
            @(negedge clk);
            #1;
            w++;
        end
        checkOutput("scoreboard_drain", expQ.size(), 0);
        expQ.delete();
        // DONE must ignore everything, including fresh tohost writes
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, TOHOST, ($urandom_range(1) == 1) ? 32'h1 : ($urandom | 32'h1));
        end
        checkOutput("frozen_cycle_cnt", cycle_cnt, lastExp.cycles);
        checkOutput("frozen_instret_cnt", instret_cnt, lastExp.instret);
        checkOutput("frozen_exit_code", exit_code, lastExp.code);
        checkOutput("frozen_flags", {done, pass, fail, timeout, core_rst},
                    {1'b1, lastExp.isPass, lastExp.isFail, lastExp.isTimeout, 1'b1});
    endtask

    // Monitor: status invariant every cycle, scoreboard compare when done rises
    initial begin
        result_t e;
        int      flags;
        forever begin
            @(negedge clk);
            flags = int'(pass) + int'(fail) + int'(timeout);
            checkOutput("status_onehot", flags, done ? 1 : 0);
            if (done && !doneSeen) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no completion");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_pass", pass, e.isPass);
                    checkOutput("sb_fail", fail, e.isFail);
                    checkOutput("sb_timeout", timeout, e.isTimeout);
                    checkOutput("sb_exit_code", exit_code, e.code);
                    checkOutput("sb_cycle_cnt", cycle_cnt, e.cycles);
                    checkOutput("sb_instret_cnt", instret_cnt, e.instret);
                    checkOutput("sb_core_rst", core_rst, 1);
                    checkOutput("sb_running", running, 0);
                end
            end
            doneSeen = done;
        end
    end

    initial begin
        int          term;
        logic [31:0] data;
        int          expSat;
        rst          = 1'b1;
        retire_valid = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        rst2         = 1'b1;
        retire2      = 1'b0;
        we2          = 1'b0;
        addr2        = 32'h0;
        wdata2       = 32'h0;
        @(negedge clk);

        // Reset sequencing followed by a passing run with 7 retires in 10 cycles
        doReset(3);
        doRun(10, 32'h1, 1'b1, 16'h01DB, 0, -1);

        // Ignored writes, then a failing report with exit code 3
        doReset(2);
        doRun(3, 32'h7, 1'b0, 16'h0, 2, -1);

        // Timeout with only ignored writes
        doReset(1);
        doRun(-1, 32'h0, 1'b0, 16'h0, 1, -1);

        // tohost on the timeout edge wins
        doReset(2);
        doRun(MAX_CYCLES - 1, 32'h1, 1'b0, 16'h0, 1, -1);

        // Reset asserted at cycle_cnt == 100
        doReset(2);
        doRun(-1, 32'h0, 1'b0, 16'h0, 1, 100);

        // Randomized runs
        for (int i = 0; i < 6; i++) begin
            term = $urandom_range(300);
            data = ($urandom_range(3) == 0) ? 32'h1 : ($urandom | 32'h1);
            doReset($urandom_range(3, 1));
            doRun(term, data, 1'b0, 16'h0, 1, -1);
        end

        // Saturation: 4-bit counters, timeout disabled, retire held high
        rst2 = 1'b1;
        @(negedge clk);
        checkOutput("sat_rst_core_rst", core_rst2, 1);
        checkOutput("sat_rst_cycle", cycle2, 0);
        rst2    = 1'b0;
        retire2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("sat_hold_core_rst", core_rst2, (i < 2) ? 1 : 0);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            expSat = (k + 1 > 15) ? 15 : k + 1;
            checkOutput("sat_cycle_cnt", cycle2, expSat);
            checkOutput("sat_instret_cnt", instret2, expSat);
            checkOutput("sat_timeout", {done2, timeout2}, 0);
        end
        we2    = 1'b1;
        addr2  = TOHOST;
        wdata2 = 32'h1;
        @(negedge clk);
        we2 = 1'b0;
        checkOutput("sat_done_flags", {done2, pass2, fail2, timeout2}, 4'b1100);
        checkOutput("sat_done_counts", {cycle2, instret2}, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Synthesizable run controller that sits between the bench and the RV32I pipeline core.
- Sequences the core reset for a parametrised number of cycles after the external reset releases.
- Counts cycles and retired instructions.
- Ends the run on either a tohost store (pass/fail with exit code) or a cycle timeout, then freezes the core.
- Replaces the fixed "hold reset, run N cycles, finish" bench flow with a reusable block whose status outputs the bench polls.

Parameters:
- RST_CYCLES, 2: clock edges core_rst stays high after rst is sampled low; legal range ≥1.
- MAX_CYCLES, 500: run-cycle budget before timeout; 0 disables timeout.
- CNT_W, 32: width of cycle_cnt and instret_cnt.
- TOHOST_ADDR, 32'h0000_1000: data-memory word address monitored for test completion.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- retire_valid  in  1  one instruction retired this cycle (WB stage)
- mem_we  in  1  data-memory write strobe from the core
- mem_addr  in  32  data-memory write address
- mem_wdata  in  32  data-memory write data
- core_rst  out  1  reset to the core, active-high
- running  out  1  high while in RUN
- done  out  1  run finished, sticky until rst
- pass  out  1  tohost reported success
- fail  out  1  tohost reported failure
- timeout  out  1  MAX_CYCLES reached without tohost
- exit_code  out  31  mem_wdata[31:1] of the terminating tohost write
- cycle_cnt  out  CNT_W  clock edges spent in RUN
- instret_cnt  out  CNT_W  retire_valid pulses counted in RUN

Behaviour:
- Reset (rst=1 at an edge):
  - state=HOLD, hold_cnt=0, core_rst=1.
  - running, done, pass, fail, timeout = 0.
  - exit_code=0, cycle_cnt=0, instret_cnt=0.
  - rst overrides everything, including mid-RUN and in DONE.
- FSM states are HOLD, RUN, DONE. All outputs are registered or decoded from the state register. core_rst = (state != RUN); running = (state == RUN).
- HOLD:
  - Each edge with rst=0 increments hold_cnt.
  - When hold_cnt == RST_CYCLES-1 at an edge, the next state is RUN.
  - core_rst therefore deasserts after exactly RST_CYCLES edges with rst low.
  - Inputs are ignored in HOLD.
- RUN, evaluated at each edge in priority order:
  1. Tohost hit: mem_we=1, mem_addr==TOHOST_ADDR and mem_wdata[0]=1.
     - Go to DONE and set done=1.
     - mem_wdata==1: pass=1, exit_code=0.
     - Otherwise: fail=1, exit_code=mem_wdata[31:1].
  2. Timeout: MAX_CYCLES≠0 and cycle_cnt==MAX_CYCLES-1. Go to DONE; set done=1, timeout=1.
  3. Otherwise stay in RUN.
- Counters in RUN:
  - cycle_cnt increments on every RUN edge, including the terminating edge. After a timeout, cycle_cnt==MAX_CYCLES.
  - instret_cnt increments on RUN edges with retire_valid=1, including the terminating edge.
  - Both saturate at all-ones and never wrap.
- Ignored writes: a tohost write with mem_wdata[0]=0 has no effect. Writes to other addresses have no effect.
- Simultaneous tohost hit and timeout edge: tohost wins, so pass/fail is set and timeout stays 0.
- DONE:
  - core_rst=1, which freezes the core.
  - Counters, flags and exit_code hold.
  - Further inputs are ignored; only rst leaves DONE.
- Exactly one of pass/fail/timeout is high whenever done=1. All three are 0 when done=0.
- Latency: status outputs are visible the cycle after the terminating edge.

Test Plan:
1. Reset sequencing: rst=1 for 3 edges, then 0. core_rst stays 1 for exactly 2 more edges (RST_CYCLES=2), then 0; running=1; cycle_cnt=0.
2. Pass: 10 RUN cycles, retire_valid high on 7 of them, then a write of 32'h1 to 32'h1000. Result: done=1, pass=1, exit_code=0, cycle_cnt=11, instret_cnt=7 (retire low on the last edge), core_rst=1.
3. Fail and ignored writes:
   - Write 32'h6 to 32'h1000: ignored, bit0=0.
   - Write 32'h7 to 32'h1004: ignored, wrong address.
   - Write 32'h7 to 32'h1000: fail=1, exit_code=3.
4. Timeout: MAX_CYCLES=500, no tohost write. At edge 500 in RUN, done=1, timeout=1, cycle_cnt=500. Counters are unchanged 20 cycles later.
5. Collision and mid-run reset:
   - Tohost write of 32'h1 on the same edge cycle_cnt==499: pass=1, timeout=0.
   - Separately, assert rst at cycle_cnt=100: all outputs return to reset values next edge, and the HOLD sequence repeats.
6. Saturation with CNT_W=4, MAX_CYCLES=0 and retire_valid held high: cycle_cnt and instret_cnt stick at 15, and no timeout ever fires.
